// File: rtl/mem_write_monitor_pkg.sv
// Shared types and constants for the memory write monitor.
// Holds the verdict states, test ids and the pass-signature table.
package mwmon_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ID_NONE      = 2'd0,
        ID_STANDARD2 = 2'd1,
        ID_POWER2    = 2'd2,
        ID_LOADSTORE = 2'd3
    } test_id_t;

    localparam int SIG_AW = 64;
    localparam int SIG_DW = 64;
    localparam int NSIG   = 3;

    typedef struct packed {
        logic [SIG_AW-1:0] addr;
        logic [SIG_DW-1:0] data;
        test_id_t          id;
    } sig_t;

    // Entries are listed in priority order, index 0 first.
    localparam sig_t SIGS [NSIG] = '{
        '{addr: 64'd84,  data: 64'd7, id: ID_STANDARD2},
        '{addr: 64'd128, data: 64'd7, id: ID_POWER2},
        '{addr: 64'd80,  data: 64'd1, id: ID_LOADSTORE}
    };

endpackage

// File: rtl/mem_write_monitor_if.sv
// Processor data-memory write port as seen by the monitor.
// The processor drives it (master); the monitor observes it (slave).
interface mem_write_monitor_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [1:0]        memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;

    modport master (
        output memwrite,
        output dataadr,
        output writedata
    );

    modport slave (
        input memwrite,
        input dataadr,
        input writedata
    );
endinterface

// File: rtl/mem_write_monitor_sig_match.sv
// Combinational lookup of an (address, data) pair in the signature table.
// The lowest-indexed matching entry wins.
module sig_match
    import mwmon_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              hit,
    output test_id_t          id
);

    // Scan from lowest priority upward so the first entry overrides.
    always_comb begin
        hit = 1'b0;
        id  = ID_NONE;
        for (int i = NSIG - 1; i >= 0; i--) begin
            if (addr == ADDR_W'(SIGS[i].addr) &&
                data == DATA_W'(SIGS[i].data)) begin
                hit = 1'b1;
                id  = SIGS[i].id;
            end
        end
    end

endmodule

// File: rtl/mem_write_monitor.sv
// Self-check stage watching the processor's data-memory writes.
// Latches a sticky PASS on a signature write or FAIL on watchdog timeout.
module mem_write_monitor
    import mwmon_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 48
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    mem_write_monitor_if.slave  bus,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          test_id,
    output logic [CNT_W-1:0]    cycles,
    output logic [7:0]          write_count,
    output logic [ADDR_W-1:0]   last_addr,
    output logic [DATA_W-1:0]   last_data
);

    state_t           state;
    test_id_t         tid;
    logic             wr;
    logic             hit;
    test_id_t         hit_id;
    logic [CNT_W-1:0] cyc_nx;

    assign wr     = (bus.memwrite != 2'd0);
    assign cyc_nx = cycles + 1'b1;

    sig_match #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match (
        .addr (bus.dataadr),
        .data (bus.writedata),
        .hit  (hit),
        .id   (hit_id)
    );

    assign done    = (state != ST_RUN);
    assign pass    = (state == ST_PASS);
    assign fail    = (state == ST_FAIL);
    assign test_id = tid;

    // Verdict FSM, watchdog counter and last-write capture; frozen once done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            tid         <= ID_NONE;
            cycles      <= '0;
            write_count <= '0;
            last_addr   <= '0;
            last_data   <= '0;
        end else if (clr) begin
            state       <= ST_RUN;
            tid         <= ID_NONE;
            cycles      <= '0;
            write_count <= '0;
            last_addr   <= '0;
            last_data   <= '0;
        end else if (state == ST_RUN) begin
            cycles <= cyc_nx;
            if (wr) begin
                if (write_count != 8'hFF)
                    write_count <= write_count + 8'd1;
                last_addr <= bus.dataadr;
                last_data <= bus.writedata;
            end
            if (wr && hit) begin
                state <= ST_PASS;
                tid   <= hit_id;
            end else if (cyc_nx == CNT_W'(TIMEOUT)) begin
                state <= ST_FAIL;
                tid   <= ID_NONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed and randomized bench for mem_write_monitor.
// Outputs are compared against a behavioural model every clock.
module tb_mem_write_monitor;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int CW = 10;
    localparam int TO = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr;
    logic          done;
    logic          pass;
    logic          fail;
    logic [1:0]    test_id;
    logic [CW-1:0] cycles;
    logic [7:0]    write_count;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    int compared   = 0;
    int mismatched = 0;

    // model: verdict 0 running, 1 passed, 2 failed
    int          m_verdict;
    int          m_id;
    int          m_cycles;
    int          m_wc;
    logic [63:0] m_la;
    logic [63:0] m_ld;

    mem_write_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) mw_if ();

    mem_write_monitor #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .CNT_W   (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .bus         (mw_if),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .test_id     (test_id),
        .cycles      (cycles),
        .write_count (write_count),
        .last_addr   (last_addr),
        .last_data   (last_data)
    );

    always #5 clk = ~clk;

    function automatic int lookup(logic [63:0] a, logic [63:0] d);
        if (a == 64'd84 && d == 64'd7)  return 1;
        if (a == 64'd128 && d == 64'd7) return 2;
        if (a == 64'd80 && d == 64'd1)  return 3;
        return 0;
    endfunction

    task automatic model_clear();
        m_verdict = 0;
        m_id      = 0;
        m_cycles  = 0;
        m_wc      = 0;
        m_la      = '0;
        m_ld      = '0;
    endtask

    task automatic model_edge(logic [1:0] mw, logic [63:0] a,
                              logic [63:0] d, logic c);
        int hit;
        if (c) begin
            model_clear();
        end else if (m_verdict == 0) begin
            m_cycles++;
            hit = 0;
            if (mw != 0) begin
                m_wc = (m_wc < 255) ? m_wc + 1 : 255;
                m_la = a;
                m_ld = d;
                hit  = lookup(a, d);
            end
            if (hit != 0) begin
                m_verdict = 1;
                m_id      = hit;
            end else if (m_cycles == TO) begin
                m_verdict = 2;
                m_id      = 0;
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("done", 64'(done), 64'(m_verdict != 0));
        chk("pass", 64'(pass), 64'(m_verdict == 1));
        chk("fail", 64'(fail), 64'(m_verdict == 2));
        chk("test_id", 64'(test_id), 64'(m_id));
        chk("cycles", 64'(cycles), 64'(m_cycles));
        chk("write_count", 64'(write_count), 64'(m_wc));
        chk("last_addr", last_addr, m_la);
        chk("last_data", last_data, m_ld);
    endtask

    // one clock: drive, take the edge, update model, sample 1ns later
    task automatic step(logic [1:0] mw, logic [63:0] a,
                        logic [63:0] d, logic c);
        mw_if.memwrite  = mw;
        mw_if.dataadr   = a;
        mw_if.writedata = d;
        clr             = c;
        @(posedge clk);
        model_edge(mw, a, d, c);
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(2'd0, '0, '0, 1'b0);
    endtask

    // asynchronous reset pulse away from any clock edge
    task automatic async_reset();
        #1;
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rd;
        logic [1:0]  rmw;
        logic        rc;
        reset           = 1'b1;
        clr             = 1'b0;
        mw_if.memwrite  = '0;
        mw_if.dataadr   = '0;
        mw_if.writedata = '0;
        model_clear();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // standard2 signature on edge 10, later writes ignored
        idle(9);
        step(2'd1, 64'd84, 64'd7, 1'b0);
        step(2'd3, 64'd128, 64'd7, 1'b0);
        step(2'd2, 64'd999, 64'd5, 1'b0);
        idle(3);

        // near miss on edge 3, power2 on edge 5
        async_reset();
        idle(2);
        step(2'd1, 64'd128, 64'd6, 1'b0);
        step(2'd0, 64'd128, 64'd7, 1'b0);
        step(2'd2, 64'd128, 64'd7, 1'b0);
        idle(2);

        // timeout with no matching write, cycles freezes
        async_reset();
        step(2'd1, 64'd84, 64'd8, 1'b0);
        idle(TO + 5);

        // loadstore on the timeout edge wins
        async_reset();
        idle(TO - 1);
        step(2'd1, 64'd80, 64'd1, 1'b0);
        idle(2);

        // clr from PASS with a write, then fresh signature
        step(2'd1, 64'd84, 64'd7, 1'b1);
        step(2'd1, 64'd84, 64'd7, 1'b0);
        idle(2);

        // async reset mid-run at cycles=20, then full timeout
        step(2'd0, '0, '0, 1'b1);
        idle(20);
        async_reset();
        idle(TO + 2);

        // randomized runs with occasional clr
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 64'd84;
                1: ra = 64'd128;
                2: ra = 64'd80;
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0: rd = 64'd7;
                1: rd = 64'd1;
                2: rd = 64'd6;
                default: rd = {$urandom, $urandom};
            endcase
            rmw = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3))
                                              : 2'd0;
            rc  = ($urandom_range(0, 39) == 0);
            step(rmw, ra, rd, rc);
            if ($urandom_range(0, 149) == 0)
                async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
